// File: rtl/spi_master.sv
// SPI mode-0 initiator: MSB-first DATA_W-bit words, optional multi-word frames
// holding ssel_ low, all outputs registered.
module spi_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              ssel_
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_NEXT, HOLD, GAP} state_t;

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    state_t            state;
    logic [CW-1:0]     half_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              last_word;
    logic              accept;
    logic              half_done;

    assign accept    = tx_valid && tx_ready;
    assign half_done = (half_cnt == HALF_LAST);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            last_word <= 1'b0;
            tx_ready  <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            ssel_     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE, WAIT_NEXT: begin
                    if (accept) begin
                        state     <= SETUP;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        ssel_     <= 1'b0;
                        mosi      <= tx_data[DATA_W-1];
                        tx_shift  <= tx_data;
                        last_word <= tx_last;
                        half_cnt  <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SETUP: begin
                    // The first rising sck edge is issued here, so SHIFT always starts with sck high.
                    if (half_done) begin
                        half_cnt <= '0;
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                        state    <= SHIFT;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        sck      <= ~sck;
                        if (!sck) begin
                            rx_shift <= {rx_shift[DATA_W-2:0], miso};
                        end else if (bit_cnt == BIT_LAST) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (last_word) begin
                                state <= HOLD;
                            end else begin
                                state    <= WAIT_NEXT;
                                tx_ready <= 1'b1;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            mosi     <= tx_shift[DATA_W-2];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        ssel_    <= 1'b1;
                        state    <= GAP;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
